// File: rtl/gpu_blitter.sv
// gpu_blitter: rectangle blitter with a command FIFO.
// Executes DRAW (image copy from pixel memory, optional X/Y mirroring), FILL (solid
// rectangle) and CLEAR (whole framebuffer) commands in order. Destination pixels are
// clipped one at a time against the framebuffer.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command push handshake (cmd_ready = FIFO not full)
//   cmd_*                   command fields, captured together on push
//   busy                    FIFO non-empty or engine running
//   mem_addr/mem_read       pixel memory read request, held until mem_valid
//   mem_data/mem_valid      pixel memory read response
//   fb_x/fb_y/fb_color      registered framebuffer write, qualified by fb_write
module gpu_blitter #(
    parameter int unsigned FB_WIDTH  = 400,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned COLOR_W   = 16,
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [31:0]                  cmd_addr,
    input  logic [15:0]                  cmd_src_x,
    input  logic [15:0]                  cmd_src_y,
    input  logic [15:0]                  cmd_img_width,
    input  logic [$clog2(FB_WIDTH)+1:0]  cmd_width,
    input  logic [$clog2(FB_HEIGHT)+1:0] cmd_height,
    input  logic [15:0]                  cmd_x,
    input  logic [15:0]                  cmd_y,
    input  logic                         cmd_flip_x,
    input  logic                         cmd_flip_y,
    input  logic [COLOR_W-1:0]           cmd_color,
    output logic                         busy,
    output logic [31:0]                  mem_addr,
    output logic                         mem_read,
    input  logic [COLOR_W-1:0]           mem_data,
    input  logic                         mem_valid,
    output logic [$clog2(FB_WIDTH):0]    fb_x,
    output logic [$clog2(FB_HEIGHT):0]   fb_y,
    output logic [COLOR_W-1:0]           fb_color,
    output logic                         fb_write
);

    localparam int unsigned XW = $clog2(FB_WIDTH);
    localparam int unsigned YW = $clog2(FB_HEIGHT);
    localparam int unsigned PW = $clog2(CMD_DEPTH);

    localparam logic [1:0] OpDraw  = 2'd0;
    localparam logic [1:0] OpClear = 2'd2;
    localparam logic [1:0] OpRsvd  = 2'd3;

    localparam logic [XW+1:0] FullW = (XW + 2)'(FB_WIDTH);
    localparam logic [YW+1:0] FullH = (YW + 2)'(FB_HEIGHT);

    typedef struct packed {
        logic [1:0]         op;
        logic [31:0]        addr;
        logic [15:0]        src_x;
        logic [15:0]        src_y;
        logic [15:0]        img_width;
        logic [XW+1:0]      width;
        logic [YW+1:0]      height;
        logic [15:0]        x;
        logic [15:0]        y;
        logic               flip_x;
        logic               flip_y;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    typedef enum logic [0:0] {StIdle = 1'b0, StRun = 1'b1} state_e;

    // ------------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    cmd_t          fifo_mem [CMD_DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;
    cmd_t          cmd_in, head_eff;
    logic          head_nop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign cmd_in = '{
        op:        cmd_op,
        addr:      cmd_addr,
        src_x:     cmd_src_x,
        src_y:     cmd_src_y,
        img_width: cmd_img_width,
        width:     cmd_width,
        height:    cmd_height,
        x:         cmd_x,
        y:         cmd_y,
        flip_x:    cmd_flip_x,
        flip_y:    cmd_flip_y,
        color:     cmd_color
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= cmd_in;
    end

    // CLEAR is rewritten into a full-screen rectangle at load time so the run loop
    // only ever sees FILL-like geometry.
    always_comb begin
        head_eff = fifo_mem[rd_ptr_q[PW-1:0]];
        if (head_eff.op == OpClear) begin
            head_eff.width  = FullW;
            head_eff.height = FullH;
            head_eff.x      = '0;
            head_eff.y      = '0;
        end
    end

    assign head_nop = (head_eff.op == OpRsvd) || (head_eff.width == '0) ||
                      (head_eff.height == '0);

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    cmd_t          cur_q;
    logic          nop_q;
    logic [XW+1:0] px_q, px_d;
    logic [YW+1:0] py_q, py_d;
    logic          pix_done;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        px_d    = px_q;
        py_d    = py_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    px_d    = '0;
                    py_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (nop_q) begin
                    state_d = StIdle;
                end else if (pix_done) begin
                    if (px_q == cur_q.width - 1'b1) begin
                        px_d = '0;
                        if (py_q == cur_q.height - 1'b1) state_d = StIdle;
                        else                              py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // DRAW pixels complete on mem_valid; FILL/CLEAR pixels complete every cycle.
    always_comb begin
        mem_read = 1'b0;
        pix_done = 1'b0;
        if (state_q == StRun && !nop_q) begin
            if (cur_q.op == OpDraw) begin
                mem_read = 1'b1;
                pix_done = mem_valid;
            end else begin
                pix_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q <= '0;
            nop_q <= 1'b0;
            px_q  <= '0;
            py_q  <= '0;
        end else begin
            if (pop) begin
                cur_q <= head_eff;
                nop_q <= head_nop;
            end
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign busy = !fifo_empty || (state_q != StIdle);

    // ------------------------------------------------------------------
    // Source address (modulo 2^32)
    // ------------------------------------------------------------------
    logic [XW+1:0] sx;
    logic [YW+1:0] sy;
    logic [31:0]   src_row, addr_calc;

    assign sx        = cur_q.flip_x ? (cur_q.width - 1'b1 - px_q) : px_q;
    assign sy        = cur_q.flip_y ? (cur_q.height - 1'b1 - py_q) : py_q;
    assign src_row   = 32'(cur_q.src_y) + 32'(sy);
    assign addr_calc = cur_q.addr + 32'(cur_q.src_x) + 32'(sx) +
                       src_row * 32'(cur_q.img_width);
    assign mem_addr  = mem_read ? addr_calc : '0;

    // ------------------------------------------------------------------
    // Destination clipping and framebuffer write register
    // ------------------------------------------------------------------
    logic [16:0] dx, dy;
    logic        in_bounds, pix_wr;

    // 17-bit two's complement: sign-extended origin plus unsigned offset
    assign dx = {cur_q.x[15], cur_q.x} + 17'(px_q);
    assign dy = {cur_q.y[15], cur_q.y} + 17'(py_q);

    assign in_bounds = !dx[16] && (dx[15:0] < 16'(FB_WIDTH)) &&
                       !dy[16] && (dy[15:0] < 16'(FB_HEIGHT));
    assign pix_wr    = pix_done && in_bounds && ((cur_q.op != OpDraw) || mem_data[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_write <= 1'b0;
            fb_x     <= '0;
            fb_y     <= '0;
            fb_color <= '0;
        end else begin
            fb_write <= pix_wr;
            if (pix_wr) begin
                fb_x     <= dx[XW:0];
                fb_y     <= dy[YW:0];
                fb_color <= (cur_q.op == OpDraw) ? mem_data : cur_q.color;
            end
        end
    end

endmodule

// File: tb/tb_gpu_blitter.sv
`timescale 1ns/1ps
// Scoreboard bench for gpu_blitter. A reference model expands each accepted command
// into the expected memory addresses and framebuffer writes; monitors compare them
// against the DUT as it produces them. Reduced framebuffer keeps CLEAR short.
module tb_gpu_blitter;
    localparam int FBW   = 40;
    localparam int FBH   = 24;
    localparam int DEPTH = 4;
    localparam int XW    = $clog2(FBW);
    localparam int YW    = $clog2(FBH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [31:0]       cmd_addr = '0;
    logic [15:0]       cmd_src_x = '0, cmd_src_y = '0, cmd_img_width = '0;
    logic [XW+1:0]     cmd_width = '0;
    logic [YW+1:0]     cmd_height = '0;
    logic [15:0]       cmd_x = '0, cmd_y = '0;
    logic              cmd_flip_x = 1'b0, cmd_flip_y = 1'b0;
    logic [15:0]       cmd_color = '0;
    logic              busy;
    logic [31:0]       mem_addr;
    logic              mem_read;
    logic [15:0]       mem_data = '0;
    logic              mem_valid = 1'b0;
    logic [XW:0]       fb_x;
    logic [YW:0]       fb_y;
    logic [15:0]       fb_color;
    logic              fb_write;

    always #5 clk = ~clk;

    gpu_blitter #(
        .FB_WIDTH (FBW),
        .FB_HEIGHT(FBH),
        .COLOR_W  (16),
        .CMD_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_src_x    (cmd_src_x),
        .cmd_src_y    (cmd_src_y),
        .cmd_img_width(cmd_img_width),
        .cmd_width    (cmd_width),
        .cmd_height   (cmd_height),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_flip_x   (cmd_flip_x),
        .cmd_flip_y   (cmd_flip_y),
        .cmd_color    (cmd_color),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_color     (fb_color),
        .fb_write     (fb_write)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [15:0] src_x, src_y, img_w;
        int          w, h, x, y;
        logic        fx, fy;
        logic [15:0] color;
    } bcmd_t;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] c;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] addr_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_count = 0;
    int          max_stall = 0;
    bit          valid_noise = 1'b0;
    int          mem_mode = 0;
    int          stall_left = 0;

    // Pixel memory contents as a pure function of address
    function automatic logic [15:0] memval(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        if (mem_mode == 0) return a[15:0] | 16'h0001;
        return h[31:16];
    endfunction

    function automatic bcmd_t mk(input logic [1:0] op, input logic [31:0] addr,
                                 input int sx, input int sy, input int iw, input int w,
                                 input int h, input int x, input int y, input logic fx,
                                 input logic fy, input logic [15:0] color);
        bcmd_t c;
        c.op = op; c.addr = addr; c.src_x = 16'(sx); c.src_y = 16'(sy); c.img_w = 16'(iw);
        c.w = w; c.h = h; c.x = x; c.y = y; c.fx = fx; c.fy = fy; c.color = color;
        return c;
    endfunction

    // Reference model: expand one command into reads and writes, row-major
    function automatic void model(input bcmd_t c);
        int w, h, x0, y0, dx, dy, sx, sy;
        bit inb;
        logic [31:0] a;
        logic [15:0] d;
        w = c.w; h = c.h; x0 = c.x; y0 = c.y;
        if (c.op == 2'd2) begin
            w = FBW; h = FBH; x0 = 0; y0 = 0;
        end
        if (c.op == 2'd3 || w == 0 || h == 0) return;
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                dx  = x0 + px;
                dy  = y0 + py;
                inb = (dx >= 0) && (dx < FBW) && (dy >= 0) && (dy < FBH);
                if (c.op == 2'd0) begin
                    sx = c.fx ? (w - 1 - px) : px;
                    sy = c.fy ? (h - 1 - py) : py;
                    a  = c.addr + 32'(c.src_x) + 32'(sx) +
                         (32'(c.src_y) + 32'(sy)) * 32'(c.img_w);
                    addr_q.push_back(a);
                    d = memval(a);
                    if (inb && d[0]) exp_q.push_back('{dx, dy, d});
                end else if (inb) begin
                    exp_q.push_back('{dx, dy, c.color});
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Memory responder: random stall before each response, optional noise on mem_valid
    always @(negedge clk) begin
        if (mem_read) begin
            if (stall_left == 0) begin
                mem_valid  = 1'b1;
                mem_data   = memval(mem_addr);
                stall_left = int'($urandom_range(max_stall, 0));
            end else begin
                mem_valid  = 1'b0;
                mem_data   = 16'($urandom);
                stall_left = stall_left - 1;
            end
        end else begin
            mem_valid = valid_noise ? 1'($urandom) : 1'b0;
            mem_data  = 16'($urandom);
        end
    end

    // Monitor: framebuffer writes and memory requests against the scoreboard
    always @(negedge clk) begin : monitor
        wr_t e;
        #1;
        if (fb_write) begin
            wr_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL fb_unexpected: got write (%0d,%0d,0x%0h) want no write",
                         fb_x, fb_y, fb_color);
            end else begin
                e = exp_q.pop_front();
                if (fb_x !== (XW + 1)'(e.x) || fb_y !== (YW + 1)'(e.y) || fb_color !== e.c) begin
                    miscompares++;
                    $display("FAIL fb_pixel: got (%0d,%0d,0x%0h) want (%0d,%0d,0x%0h)",
                             fb_x, fb_y, fb_color, e.x, e.y, e.c);
                end
            end
        end
        if (mem_read) begin
            vectors++;
            if (addr_q.size() == 0) begin
                miscompares++;
                $display("FAIL mem_unexpected: got read at 0x%0h want no read", mem_addr);
            end else begin
                if (mem_addr !== addr_q[0]) begin
                    miscompares++;
                    $display("FAIL mem_addr: got 0x%0h want 0x%0h", mem_addr, addr_q[0]);
                end
                if (mem_valid && !reset) void'(addr_q.pop_front());
            end
        end
    end

    task automatic drive(input bcmd_t c);
        cmd_op = c.op; cmd_addr = c.addr; cmd_src_x = c.src_x; cmd_src_y = c.src_y;
        cmd_img_width = c.img_w; cmd_width = (XW + 2)'(c.w); cmd_height = (YW + 2)'(c.h);
        cmd_x = 16'(c.x); cmd_y = 16'(c.y); cmd_flip_x = c.fx; cmd_flip_y = c.fy;
        cmd_color = c.color;
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge
    task automatic push(input bcmd_t c);
        int guard;
        guard = 0;
        drive(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got cmd_ready=0 want 1 within 5000 cycles");
        end else begin
            model(c);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        #2;
        while (busy && guard < 20000) begin
            @(negedge clk);
            #2;
            guard++;
        end
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_reads_left"}, 64'(addr_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_mem_read"}, 64'(mem_read), 64'd0);
        check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_fb_write"}, 64'(fb_write), 64'd0);
        check({name, "_fb_x"}, 64'(fb_x), 64'd0);
        check({name, "_fb_y"}, 64'(fb_y), 64'd0);
        check({name, "_fb_color"}, 64'(fb_color), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish want finish within 600000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bcmd_t c;
        bcmd_t b2b[DEPTH+1];
        int    c0, r;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        // FILL timing: first write two cycles after the accepting edge, then back to back
        push(mk(2'd1, 0, 0, 0, 0, 3, 2, 10, 20, 0, 0, 16'hF801));
        check("fill_lat0", 64'(fb_write), 64'd0);
        @(negedge clk);
        check("fill_lat1", 64'(fb_write), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fill_burst", 64'(fb_write), 64'd1);
        end
        @(negedge clk);
        check("fill_end", 64'(fb_write), 64'd0);
        wait_idle("fill");

        // DRAW with zero-wait memory, plain and mirrored
        push(mk(2'd0, 32'h1000, 2, 1, 8, 2, 2, 5, 5, 0, 0, 0));
        wait_idle("draw");
        push(mk(2'd0, 32'h1000, 2, 1, 8, 2, 2, 5, 5, 1, 0, 0));
        wait_idle("draw_fx");
        push(mk(2'd0, 32'h1000, 2, 1, 8, 2, 2, 5, 5, 1, 1, 0));
        wait_idle("draw_fxy");

        // Clipped DRAW at the bottom-left corner
        c0 = wr_count;
        push(mk(2'd0, 32'h2000, 0, 0, 16, 3, 2, -1, FBH - 1, 0, 0, 0));
        wait_idle("draw_clip");
        check("draw_clip_count", 64'(wr_count - c0), 64'd2);
        mem_mode = 1;
        push(mk(2'd0, 32'h2345, 3, 7, 21, 3, 2, -1, FBH - 1, 0, 1, 0));
        wait_idle("draw_clip_hash");

        // FIFO fill: keep the engine busy, then offer DEPTH+1 commands with valid held
        push(mk(2'd1, 0, 0, 0, 0, 20, 4, 0, 0, 0, 0, 16'h1234));
        @(negedge clk);
        for (int i = 0; i <= DEPTH; i++)
            b2b[i] = mk(2'd1, 0, 0, 0, 0, 3, 2, i * 4, 10 + i, 0, 0, 16'($urandom));
        cmd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(b2b[i]);
            check("fifo_ready", 64'(cmd_ready), 64'd1);
            model(b2b[i]);
            @(negedge clk);
        end
        drive(b2b[DEPTH]);
        check("fifo_full_ready", 64'(cmd_ready), 64'd0);
        check("fifo_full_busy", 64'(busy), 64'd1);
        push(b2b[DEPTH]);
        wait_idle("fifo");

        // CLEAR covers the whole framebuffer; zero-size and reserved commands write nothing
        c0 = wr_count;
        push(mk(2'd2, 0, 0, 0, 0, 3, 3, 7, 7, 0, 0, 16'h0000));
        wait_idle("clear");
        check("clear_count", 64'(wr_count - c0), 64'(FBW * FBH));
        c0 = wr_count;
        push(mk(2'd1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 16'hFFFF));
        wait_idle("fill_w0");
        push(mk(2'd3, 0, 0, 0, 0, 3, 3, 1, 1, 0, 0, 16'hFFFF));
        wait_idle("op3");
        check("nop_count", 64'(wr_count - c0), 64'd0);

        // Randomized commands with memory stalls and mem_valid noise
        max_stall   = 5;
        valid_noise = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(19, 0));
            c = mk((r < 9) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd3 : 2'd2,
                   $urandom, int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)),
                   int'($urandom_range(64, 1)), int'($urandom_range(6, 0)),
                   int'($urandom_range(6, 0)), int'($urandom_range(FBW + 12, 0)) - 8,
                   int'($urandom_range(FBH + 12, 0)) - 8, 1'($urandom), 1'($urandom),
                   16'($urandom));
            if (r == 8) c.x = -30000;
            push(c);
        end
        wait_idle("random");

        // Reset in the middle of a stalled DRAW
        push(mk(2'd0, $urandom, 4, 4, 32, 6, 4, 2, 2, 1'($urandom), 1'($urandom), 0));
        repeat (int'($urandom_range(20, 5))) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("post_reset_fb_write", 64'(fb_write), 64'd0);
            check("post_reset_mem_read", 64'(mem_read), 64'd0);
            check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
            check("post_reset_busy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        push(mk(2'd1, 0, 0, 0, 0, 2, 2, FBW - 1, FBH - 1, 0, 0, 16'hABCD));
        wait_idle("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
